// File: rtl/quadrature_decoder_pkg.sv
// quadrature_decoder_pkg: Gray states, direction type and quarter-step classifier.
package quadrature_decoder_pkg;
  localparam logic [1:0] ENC_S00 = 2'b00;
  localparam logic [1:0] ENC_S01 = 2'b01;
  localparam logic [1:0] ENC_S11 = 2'b11;
  localparam logic [1:0] ENC_S10 = 2'b10;

  typedef enum logic [1:0] {DIR_NONE, DIR_CW, DIR_CCW, DIR_ERR} dir_t;

  function automatic logic [1:0] cw_next(input logic [1:0] s);
    return s == ENC_S00 ? ENC_S01 : s == ENC_S01 ? ENC_S11 : s == ENC_S11 ? ENC_S10 : ENC_S00;
  endfunction

  function automatic dir_t quad_dir(input logic [1:0] prev, input logic [1:0] curr);
    return prev == curr ? DIR_NONE :
           curr == cw_next(prev) ? DIR_CW :
           prev == cw_next(curr) ? DIR_CCW : DIR_ERR;
  endfunction
endpackage

// File: rtl/quadrature_decoder_debouncer.sv
// input_debouncer: 2-FF synchroniser plus persistence counter for WIDTH async pins.
module input_debouncer #(
  parameter int WIDTH = 2,
  parameter int DEBOUNCE_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1, s2;
  logic [CW-1:0] cnt;
  // A new value must differ from stable for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == stable) cnt <= '0;
      else if (cnt == LAST) begin
        stable <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/quadrature_decoder.sv
// quadrature_decoder: debounced A/B quadrature to a bounded wrapping up/down count.
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int WIRES = 4,
  parameter int MIN = 0,
  parameter int MAX = 2**WIRES - 1,
  parameter int INIT = MIN,
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIRES-1:0] count,
  output logic             step_up,
  output logic             step_down,
  output logic             error
);
  localparam int HOLD = DEBOUNCE_CYCLES + 3;
  localparam int HW = $clog2(HOLD);
  localparam int AW = $clog2(STEPS_PER_DETENT) + 2;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic signed [AW-1:0] ACC_TOP = AW'(STEPS_PER_DETENT - 1);
  localparam logic signed [AW-1:0] ACC_BOT = AW'(1 - STEPS_PER_DETENT);
  localparam logic signed [AW-1:0] ACC_ONE = AW'(1);
  localparam logic [WIRES-1:0] LO = WIRES'(MIN);
  localparam logic [WIRES-1:0] HI = WIRES'(MAX);
  localparam logic [WIRES-1:0] RST_V = WIRES'(INIT);

  logic [1:0] stable, prev;
  logic [HW-1:0] hold;
  logic armed;
  logic signed [AW-1:0] acc;
  dir_t dir;

  input_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk_in),
    .rst(rst_in),
    .din({enc_a, enc_b}),
    .stable(stable)
  );

  assign dir = quad_dir(prev, stable);

  // prev tracks stable during the post-reset hold so resting non-00 pins decode as no motion.
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      count <= RST_V;
      step_up <= 1'b0;
      step_down <= 1'b0;
      error <= 1'b0;
      prev <= '0;
      hold <= '0;
      armed <= 1'b0;
      acc <= '0;
    end else begin
      step_up <= 1'b0;
      step_down <= 1'b0;
      error <= 1'b0;
      prev <= stable;
      if (!armed) begin
        hold <= hold + 1'b1;
        armed <= hold == HOLD_LAST;
      end else if (dir == DIR_ERR) begin
        error <= 1'b1;
        acc <= '0;
      end else if (dir == DIR_CW) begin
        if (acc == ACC_TOP) begin
          acc <= '0;
          step_up <= 1'b1;
          count <= count < HI ? count + 1'b1 : LO;
        end else acc <= acc + ACC_ONE;
      end else if (dir == DIR_CCW) begin
        if (acc == ACC_BOT) begin
          acc <= '0;
          step_down <= 1'b1;
          count <= count > LO ? count - 1'b1 : HI;
        end else acc <= acc - ACC_ONE;
      end
    end
endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: directed + random pin stimulus against a windowed reference model.
module tb_quadrature_decoder;
  localparam int D = 4, S = 4, MN = 0, MX = 15, IV = 0;
  logic clk_in = 1'b0, rst_in = 1'b1, enc_a = 1'b1, enc_b = 1'b1;
  logic [3:0] count;
  logic step_up, step_down, error;

  quadrature_decoder #(.WIRES(4), .MIN(MN), .MAX(MX), .INIT(IV),
                       .DEBOUNCE_CYCLES(D), .STEPS_PER_DETENT(S)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enc_a(enc_a), .enc_b(enc_b),
    .count(count), .step_up(step_up), .step_down(step_down), .error(error)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0, miscompares = 0;
  logic [1:0] samp[$];
  logic [1:0] st[$];
  int e, t0, acc, mcount, ups, downs, errs;
  logic [1:0] ms;
  logic eu, ed, ee;

  function automatic int gpos(input logic [1:0] v);
    return v == 2'b00 ? 0 : v == 2'b01 ? 1 : v == 2'b11 ? 2 : 3;
  endfunction

  function automatic logic [1:0] gray(input int p);
    int q;
    q = ((p % 4) + 4) % 4;
    return q == 0 ? 2'b00 : q == 1 ? 2'b01 : q == 2 ? 2'b11 : 2'b10;
  endfunction

  function automatic logic [1:0] s_at(input int k);
    return k < 1 ? 2'b00 : samp[k-1];
  endfunction

  function automatic logic [1:0] st_at(input int k);
    return k < 1 ? 2'b00 : st[k-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    st.delete();
    e = 0; t0 = 0; acc = 0; mcount = IV; ms = 2'b00;
  endtask

  // One clock edge: advance the model from the pins present at the edge, then compare.
  task automatic tick();
    logic [1:0] p;
    logic ok;
    int d;
    logic [3:0] ec;
    p = {enc_a, enc_b};
    @(posedge clk_in);
    e++;
    samp.push_back(p);
    eu = 0; ed = 0; ee = 0;
    if (e >= D + 4) begin
      d = ((gpos(st_at(e-1)) - gpos(st_at(e-2))) % 4 + 4) % 4;
      if (d == 2) begin ee = 1; acc = 0; end
      else if (d == 1) begin
        acc++;
        if (acc == S) begin acc = 0; eu = 1; mcount = mcount >= MX ? MN : mcount + 1; end
      end else if (d == 3) begin
        acc--;
        if (acc == -S) begin acc = 0; ed = 1; mcount = mcount <= MN ? MX : mcount - 1; end
      end
    end
    if (e >= t0 + D) begin
      ok = 1;
      for (int k = e - D - 1; k <= e - 2; k++) if (s_at(k) == ms) ok = 0;
      if (ok) begin ms = s_at(e-2); t0 = e; end
    end
    st.push_back(ms);
    #1;
    ec = mcount[3:0];
    check("tick", {count, step_up, step_down, error}, {ec, eu, ed, ee});
    if (step_up) ups++;
    if (step_down) downs++;
    if (error) errs++;
  endtask

  task automatic hold_pins(input logic [1:0] p, input int n);
    {enc_a, enc_b} = p;
    repeat (n) tick();
  endtask

  task automatic quarter(input int dir);
    hold_pins(gray(gpos({enc_a, enc_b}) + dir), 10);
  endtask

  task automatic detent(input int dir);
    repeat (4) quarter(dir);
  endtask

  task automatic clear_tallies();
    ups = 0; downs = 0; errs = 0;
  endtask

  initial begin
    int lat, r;
    logic orig_a;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_count", count, IV);
    check("reset_pulses", {step_up, step_down, error}, 0);
    rst_in = 1'b0;
    model_reset();
    clear_tallies();
    repeat (20) tick();
    check("idle_pulses", ups + downs + errs, 0);
    check("idle_count", count, 0);

    repeat (3) quarter(1);
    {enc_a, enc_b} = gray(gpos({enc_a, enc_b}) + 1);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step_up && lat < 0) lat = i;
    end
    check("latency", lat, 6);
    check("first_detent_count", count, 1);
    check("first_detent_ups", ups, 1);

    repeat (14) detent(1);
    check("preset_15", count, 15);
    clear_tallies();
    detent(1);
    check("wrap_up_count", count, 0);
    check("wrap_up_pulse", ups, 1);
    detent(-1);
    check("wrap_down_count", count, 15);
    check("wrap_down_pulse", downs, 1);

    clear_tallies();
    orig_a = enc_a;
    repeat (15) begin
      enc_a = ~enc_a;
      tick(); tick();
    end
    enc_a = orig_a;
    repeat (10) tick();
    check("bounce_count", count, 15);
    check("bounce_pulses", ups + downs + errs, 0);

    clear_tallies();
    hold_pins(gray(gpos({enc_a, enc_b}) + 2), 10);
    check("jump_errors", errs, 1);
    check("jump_count", count, 15);
    detent(1);
    check("after_jump_ups", ups, 1);
    check("after_jump_count", count, 0);

    detent(1);
    clear_tallies();
    quarter(1); quarter(1); quarter(-1); quarter(-1);
    check("reversal_pulses", ups + downs, 0);
    check("reversal_count", count, 1);

    {enc_a, enc_b} = gray(gpos({enc_a, enc_b}) + 1);
    tick(); tick();
    rst_in = 1'b1;
    #1;
    check("midreset_count", count, IV);
    check("midreset_pulses", {step_up, step_down, error}, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    model_reset();
    repeat (12) tick();

    repeat (250) begin
      r = $urandom_range(0, 9);
      hold_pins(r < 4 ? gray(gpos({enc_a, enc_b}) + 1) :
                r < 8 ? gray(gpos({enc_a, enc_b}) - 1) :
                r == 8 ? gray(gpos({enc_a, enc_b}) + 2) : 2'($urandom_range(0, 3)),
                $urandom_range(1, 12));
    end
    repeat (12) tick();
    check("final_count", count, mcount);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
